// File: rtl/core_pkg.sv
// Shared encodings for the MIPS core: access sizes, MEM-stage FSM states
// and the alignment rule used by the memory stage.
package core_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        MA_IDLE = 2'b00,
        MA_WAIT = 2'b01,
        MA_DONE = 2'b10
    } ma_state_t;

    // Reserved size behaves as a word, so it needs full word alignment.
    function automatic logic access_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load lane extraction and sign/zero extension.
// Kept standalone so a future data cache can reuse it.
module load_align
    import core_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed lane and extend it to 32 bits.
    always_comb begin
        byte_s = rdata[{addr_lo, 3'b000} +: 8];
        half_s = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: result = {{24{sign_ext & byte_s[7]}}, byte_s};
            SZ_HALF: result = {{16{sign_ext & half_s[15]}}, half_s};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS core: issues req/ack data memory accesses,
// stalls the pipeline until completion and presents write-back controls.
module mem_access_stage
    import core_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        RegWrite_in,
    input  logic        MemToReg_in,
    input  logic [1:0]  size_in,
    input  logic        sign_ext_in,
    input  logic [31:0] alu_out_in,
    input  logic [31:0] store_data_in,
    input  logic [4:0]  rd_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        RegWrite_out,
    output logic        MemToReg_out,
    output logic [31:0] mem_data_out,
    output logic [31:0] alu_out_out,
    output logic [4:0]  rd_out,
    output logic        misalign,
    output logic        bus_err
);

    ma_state_t       state_r, state_next_s;
    logic [TO_W-1:0] to_cnt_r, to_cnt_next_s;
    logic [31:0]     load_r, load_next_s;
    logic            bus_err_r, bus_err_next_s;

    logic            op_s;
    logic            is_load_s;
    logic            misaligned_s;
    logic            timeout_s;
    logic [31:0]     load_aligned_s;

    assign op_s         = MemRead_in | MemWrite_in;
    assign is_load_s    = MemRead_in & ~MemWrite_in;
    assign misaligned_s = access_misaligned(size_in, alu_out_in[1:0]);
    assign timeout_s    = (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));

    load_align u_load_align (
        .addr_lo  (alu_out_in[1:0]),
        .size     (size_in),
        .sign_ext (sign_ext_in),
        .rdata    (dmem_rdata),
        .result   (load_aligned_s)
    );

    // Store lane steering; EX/MEM is frozen while a request is open, so these stay stable.
    always_comb begin
        dmem_we   = MemWrite_in;
        dmem_addr = {alu_out_in[31:2], 2'b00};
        case (size_in)
            SZ_BYTE: begin
                dmem_be    = 4'b0001 << alu_out_in[1:0];
                dmem_wdata = {4{store_data_in[7:0]}};
            end
            SZ_HALF: begin
                dmem_be    = alu_out_in[1] ? 4'b1100 : 4'b0011;
                dmem_wdata = {2{store_data_in[15:0]}};
            end
            default: begin
                dmem_be    = 4'b1111;
                dmem_wdata = store_data_in;
            end
        endcase
    end

    // Access FSM next-state and MEM/WB-facing outputs.
    always_comb begin
        state_next_s   = state_r;
        to_cnt_next_s  = to_cnt_r;
        load_next_s    = load_r;
        bus_err_next_s = bus_err_r;
        dmem_req       = 1'b0;
        stall          = 1'b0;
        RegWrite_out   = RegWrite_in;
        MemToReg_out   = MemToReg_in;
        mem_data_out   = 32'h0000_0000;
        alu_out_out    = alu_out_in;
        rd_out         = rd_in;
        misalign       = 1'b0;
        bus_err        = 1'b0;

        if (rst) begin
            case (state_r)
                MA_IDLE: begin
                    if (op_s && misaligned_s) begin
                        misalign     = 1'b1;
                        RegWrite_out = 1'b0;
                    end else if (op_s) begin
                        // Write-back is held off while stalled so MEM/WB sees a bubble.
                        dmem_req       = 1'b1;
                        stall          = 1'b1;
                        RegWrite_out   = 1'b0;
                        bus_err_next_s = 1'b0;
                        if (dmem_ack) begin
                            state_next_s = MA_DONE;
                            load_next_s  = is_load_s ? load_aligned_s : 32'h0000_0000;
                        end else begin
                            state_next_s  = MA_WAIT;
                            to_cnt_next_s = {TO_W{1'b0}};
                        end
                    end else begin
                        mem_data_out = 32'h0000_0000;
                    end
                end
                MA_WAIT: begin
                    dmem_req     = 1'b1;
                    stall        = 1'b1;
                    RegWrite_out = 1'b0;
                    if (dmem_ack) begin
                        state_next_s = MA_DONE;
                        load_next_s  = is_load_s ? load_aligned_s : 32'h0000_0000;
                    end else if (timeout_s) begin
                        state_next_s   = MA_DONE;
                        bus_err_next_s = 1'b1;
                        load_next_s    = 32'h0000_0000;
                    end else begin
                        to_cnt_next_s = to_cnt_r + TO_W'(1);
                    end
                end
                MA_DONE: begin
                    mem_data_out   = load_r;
                    bus_err        = bus_err_r;
                    RegWrite_out   = RegWrite_in & ~bus_err_r;
                    bus_err_next_s = 1'b0;
                    state_next_s   = MA_IDLE;
                end
                default: begin
                    state_next_s = MA_IDLE;
                end
            endcase
        end else begin
            RegWrite_out = 1'b0;
            MemToReg_out = 1'b0;
        end
    end

    // State, timeout counter, captured load data and bus-error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= MA_IDLE;
            to_cnt_r  <= {TO_W{1'b0}};
            load_r    <= 32'h0000_0000;
            bus_err_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            to_cnt_r  <= to_cnt_next_s;
            load_r    <= load_next_s;
            bus_err_r <= bus_err_next_s;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: expected completions are queued
// when an access is issued and compared when the stage reaches DONE.
module tb_mem_access_stage;
    import core_pkg::*;

    localparam int TIMEOUT = 255;
    localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemRead_in, MemWrite_in, RegWrite_in, MemToReg_in;
    logic [1:0]  size_in;
    logic        sign_ext_in;
    logic [31:0] alu_out_in, store_data_in;
    logic [4:0]  rd_in;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall, RegWrite_out, MemToReg_out, misalign, bus_err;
    logic [31:0] mem_data_out, alu_out_out;
    logic [4:0]  rd_out;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] data;
        logic        regw;
        logic        berr;
        int          stalls;
        logic        chk_data;
        logic [4:0]  rd;
        logic [31:0] alu;
    } exp_t;
    exp_t sb_q[$];

    mem_access_stage #(.TIMEOUT_CYCLES(TIMEOUT), .TO_W(8)) dut (
        .clk(clk), .rst(rst_n),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .RegWrite_in(RegWrite_in), .MemToReg_in(MemToReg_in),
        .size_in(size_in), .sign_ext_in(sign_ext_in),
        .alu_out_in(alu_out_in), .store_data_in(store_data_in), .rd_in(rd_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall(stall), .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out),
        .mem_data_out(mem_data_out), .alu_out_out(alu_out_out), .rd_out(rd_out),
        .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic drive_idle();
        MemRead_in = 1'b0; MemWrite_in = 1'b0; RegWrite_in = 1'b0; MemToReg_in = 1'b0;
        size_in = SZ_WORD; sign_ext_in = 1'b0; alu_out_in = 32'h0; store_data_in = 32'h0;
        rd_in = 5'd0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    endtask

    // Issue one aligned access; memory acks in the cycle where ack_wait stall cycles have passed.
    task automatic mem_op(input logic mr, input logic mw, input logic rw, input logic [1:0] sz,
                          input logic sx, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] rd, input int ack_wait, input logic [31:0] rdata,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_data, input logic exp_berr, input string name);
        exp_t e;
        exp_t got;
        int stalls;
        bit done;
        e.data = exp_data; e.regw = rw & ~exp_berr; e.berr = exp_berr;
        e.stalls = exp_berr ? TIMEOUT + 1 : ack_wait + 1;
        e.chk_data = mr & ~mw; e.rd = rd; e.alu = addr;
        sb_q.push_back(e);
        @(posedge clk); #1;
        MemRead_in = mr; MemWrite_in = mw; RegWrite_in = rw; MemToReg_in = mr;
        size_in = sz; sign_ext_in = sx; alu_out_in = addr; store_data_in = sdata; rd_in = rd;
        dmem_ack = (ack_wait == 0);
        dmem_rdata = (ack_wait == 0) ? rdata : JUNK;
        stalls = 0;
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (!stall) begin
                done = 1'b1;
            end else begin
                if (stalls == 0) begin
                    checks++;
                    if (dmem_req !== 1'b1 || dmem_be !== exp_be || dmem_wdata !== exp_wdata ||
                        dmem_we !== mw || dmem_addr !== {addr[31:2], 2'b00}) begin
                        failures++;
                        $display("FAIL %s_request: req=%b we=%b be=%b wdata=%h addr=%h, want req=1 we=%b be=%b wdata=%h addr=%h",
                                 name, dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_addr,
                                 mw, exp_be, exp_wdata, {addr[31:2], 2'b00});
                    end
                end
                stalls++;
                @(posedge clk); #1;
                dmem_ack = (stalls == ack_wait);
                dmem_rdata = dmem_ack ? rdata : JUNK;
            end
        end
        got = sb_q.pop_front();
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s_complete: stall still high after 400 cycles", name);
        end else begin
            if (stalls !== got.stalls || dmem_req !== 1'b0) begin
                failures++;
                $display("FAIL %s_latency: stall_cycles=%0d req_in_done=%b, want %0d and 0",
                         name, stalls, dmem_req, got.stalls);
            end
            checks++;
            if (RegWrite_out !== got.regw || bus_err !== got.berr) begin
                failures++;
                $display("FAIL %s_wb_ctrl: RegWrite_out=%b bus_err=%b, want %b %b",
                         name, RegWrite_out, bus_err, got.regw, got.berr);
            end
            checks++;
            if (rd_out !== got.rd || alu_out_out !== got.alu) begin
                failures++;
                $display("FAIL %s_passthru: rd_out=%0d alu_out_out=%h, want %0d %h",
                         name, rd_out, alu_out_out, got.rd, got.alu);
            end
            if (got.chk_data) begin
                checks++;
                if (mem_data_out !== got.data) begin
                    failures++;
                    $display("FAIL %s_data: mem_data_out=%h, want %h", name, mem_data_out, got.data);
                end
            end
        end
        dmem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        MemRead_in = 1'b1; RegWrite_in = 1'b1; MemToReg_in = 1'b1; alu_out_in = 32'h100;
        dmem_ack = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (dmem_req !== 1'b0 || stall !== 1'b0 || RegWrite_out !== 1'b0 || MemToReg_out !== 1'b0 ||
            misalign !== 1'b0 || bus_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: req=%b stall=%b rw=%b m2r=%b mis=%b berr=%b, want all 0",
                     dmem_req, stall, RegWrite_out, MemToReg_out, misalign, bus_err);
        end
        drive_idle();
        rst_n = 1'b1;
    endtask

    task automatic test_passthrough();
        @(posedge clk); #1;
        RegWrite_in = 1'b1; MemToReg_in = 1'b0; alu_out_in = 32'h1234; rd_in = 5'd5;
        #1;
        checks++;
        if (stall !== 1'b0 || dmem_req !== 1'b0 || RegWrite_out !== 1'b1 || MemToReg_out !== 1'b0 ||
            alu_out_out !== 32'h1234 || rd_out !== 5'd5 || mem_data_out !== 32'h0) begin
            failures++;
            $display("FAIL passthru: stall=%b req=%b rw=%b m2r=%b alu=%h rd=%0d data=%h, want 0 0 1 0 1234 5 0",
                     stall, dmem_req, RegWrite_out, MemToReg_out, alu_out_out, rd_out, mem_data_out);
        end
        alu_out_in = 32'h5678; rd_in = 5'd9;
        #1;
        checks++;
        if (alu_out_out !== 32'h5678 || rd_out !== 5'd9) begin
            failures++;
            $display("FAIL passthru_same_cycle: alu=%h rd=%0d, want 5678 9", alu_out_out, rd_out);
        end
    endtask

    task automatic test_loads();
        mem_op(1'b1, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h100, 32'h0, 5'd7, 0, 32'hDEADBEEF,
               4'b1111, 32'h0, 32'hDEADBEEF, 1'b0, "lw_fast");
        mem_op(1'b1, 1'b0, 1'b1, SZ_BYTE, 1'b1, 32'h103, 32'h0, 5'd8, 3, 32'h80FFFFFF,
               4'b1000, 32'h0, 32'hFFFFFF80, 1'b0, "lb");
        mem_op(1'b1, 1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h103, 32'h0, 5'd9, 3, 32'h80FFFFFF,
               4'b1000, 32'h0, 32'h00000080, 1'b0, "lbu");
        mem_op(1'b1, 1'b0, 1'b1, SZ_HALF, 1'b1, 32'h102, 32'h0, 5'd10, 1, 32'h80011234,
               4'b1100, 32'h0, 32'hFFFF8001, 1'b0, "lh");
        mem_op(1'b1, 1'b0, 1'b1, SZ_HALF, 1'b0, 32'h100, 32'h0, 5'd11, 2, 32'h80019234,
               4'b0011, 32'h0, 32'h00009234, 1'b0, "lhu");
        drive_idle();
    endtask

    task automatic test_stores();
        mem_op(1'b0, 1'b1, 1'b0, SZ_HALF, 1'b0, 32'h102, 32'h0000ABCD, 5'd0, 2, 32'h0,
               4'b1100, 32'hABCDABCD, 32'h0, 1'b0, "sh");
        mem_op(1'b0, 1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h101, 32'h1234565A, 5'd0, 0, 32'h0,
               4'b0010, 32'h5A5A5A5A, 32'h0, 1'b0, "sb");
        mem_op(1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h104, 32'hCAFE0001, 5'd0, 1, 32'h0,
               4'b1111, 32'hCAFE0001, 32'h0, 1'b0, "rw_as_sw");
        drive_idle();
    endtask

    task automatic test_misalign();
        @(posedge clk); #1;
        MemRead_in = 1'b1; RegWrite_in = 1'b1; MemToReg_in = 1'b1; size_in = SZ_WORD;
        alu_out_in = 32'h101; rd_in = 5'd3; dmem_ack = 1'b1; dmem_rdata = JUNK;
        #1;
        checks++;
        if (misalign !== 1'b1 || dmem_req !== 1'b0 || RegWrite_out !== 1'b0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL misalign_lw: mis=%b req=%b rw=%b stall=%b, want 1 0 0 0",
                     misalign, dmem_req, RegWrite_out, stall);
        end
        @(posedge clk); #1;
        size_in = SZ_HALF; alu_out_in = 32'h103;
        #1;
        checks++;
        if (misalign !== 1'b1 || dmem_req !== 1'b0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL misalign_lh_stay_idle: mis=%b req=%b stall=%b, want 1 0 0",
                     misalign, dmem_req, stall);
        end
        drive_idle();
    endtask

    task automatic test_timeout();
        mem_op(1'b1, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h200, 32'h0, 5'd12, 100000, 32'h0,
               4'b1111, 32'h0, 32'h0, 1'b1, "timeout");
        drive_idle();
    endtask

    task automatic test_back_to_back();
        mem_op(1'b1, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h300, 32'h0, 5'd13, 0, 32'h11111111,
               4'b1111, 32'h0, 32'h11111111, 1'b0, "b2b_0");
        mem_op(1'b1, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h304, 32'h0, 5'd14, 2, 32'h22222222,
               4'b1111, 32'h0, 32'h22222222, 1'b0, "b2b_1");
        mem_op(1'b0, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h308, 32'h33333333, 5'd0, 0, 32'h0,
               4'b1111, 32'h33333333, 32'h0, 1'b0, "b2b_2");
        drive_idle();
    endtask

    task automatic test_reset_midwait();
        @(posedge clk); #1;
        MemRead_in = 1'b1; RegWrite_in = 1'b1; MemToReg_in = 1'b1; size_in = SZ_WORD;
        alu_out_in = 32'h400; rd_in = 5'd15; dmem_ack = 1'b0; dmem_rdata = JUNK;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (stall !== 1'b1 || dmem_req !== 1'b1) begin
            failures++;
            $display("FAIL midwait_active: stall=%b req=%b, want 1 1", stall, dmem_req);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || dmem_req !== 1'b0 || RegWrite_out !== 1'b0) begin
            failures++;
            $display("FAIL midwait_reset_drop: stall=%b req=%b rw=%b, want 0 0 0",
                     stall, dmem_req, RegWrite_out);
        end
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || dmem_req !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle: stall=%b req=%b, want 0 0", stall, dmem_req);
        end
        mem_op(1'b1, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h404, 32'h0, 5'd16, 1, 32'hCAFEF00D,
               4'b1111, 32'h0, 32'hCAFEF00D, 1'b0, "post_reset_lw");
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_loads();
        test_stores();
        test_misalign();
        test_timeout();
        test_back_to_back();
        test_reset_midwait();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM pipeline stage of the 5-stage MIPS core.
- Sits between the EX/MEM register and the MEM/WB register.
- Performs byte, halfword and word loads and stores against a variable-latency data memory using a req/ack handshake.
- Stalls the pipeline until the access completes, then presents write-back controls, load data, ALU result and destination register to MEM/WB.

Parameters:
- TIMEOUT_CYCLES, 255: WAIT cycles without dmem_ack before declaring a bus error.
- TO_W, 8: timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset
- MemRead_in  in  1  load instruction in stage
- MemWrite_in  in  1  store instruction in stage
- RegWrite_in  in  1  write-back enable from EX/MEM
- MemToReg_in  in  1  write-back source select from EX/MEM
- size_in  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- sign_ext_in  in  1  1 = sign-extend sub-word loads (LB/LH), 0 = zero-extend
- alu_out_in  in  32  effective address / ALU result
- store_data_in  in  32  rt value for stores
- rd_in  in  5  destination register
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned address {alu_out_in[31:2],2'b00}
- dmem_be  out  4  byte enables, bit i = byte lane i (little-endian)
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  access complete; rdata valid in the same cycle for reads
- dmem_rdata  in  32  read data
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- RegWrite_out  out  1  to MEM/WB
- MemToReg_out  out  1  to MEM/WB
- mem_data_out  out  32  extended load data to MEM/WB
- alu_out_out  out  32  pass-through of alu_out_in
- rd_out  out  5  pass-through of rd_in
- misalign  out  1  misaligned access flag
- bus_err  out  1  memory timeout flag

Behaviour:
- op = MemRead_in | MemWrite_in. If both are set, treat as a store.
- Misaligned: word with addr[1:0]≠0, or half with addr[0]≠0.
- FSM states IDLE, WAIT, DONE; reset state IDLE.
- IDLE, no op: stall=0, dmem_req=0; pass controls through; mem_data_out=0.
- IDLE, op and misaligned:
  - no request is issued; stall=0; misalign=1 for that cycle.
  - RegWrite_out forced 0.
  - stay in IDLE.
- IDLE, op and aligned:
  - dmem_req=1, stall=1.
  - If dmem_ack=1 in the same cycle, go to DONE; otherwise go to WAIT and clear the timeout counter.
- WAIT: dmem_req=1, stall=1; counter increments each cycle.
  - dmem_ack=1 -> DONE.
  - Counter reaches TIMEOUT_CYCLES-1 without ack -> DONE, bus_err_q set.
- Load data capture: on the ack cycle of a read, the extracted and extended data is registered into load_q. Capture ignores dmem_rdata outside ack cycles.
- DONE:
  - dmem_req=0, stall=0.
  - mem_data_out=load_q.
  - If bus_err_q: bus_err=1, RegWrite_out=0, load_q=0.
  - Next state is always IDLE; MEM/WB captures at the end of DONE.
- Minimum memory-op latency is 2 cycles (1 stall cycle); with N wait cycles it is N+2.
- dmem_we, dmem_addr, dmem_be and dmem_wdata are driven from the stalled EX/MEM inputs. They are stable whenever dmem_req=1.
- Byte enables:
  - byte: 1<<addr[1:0]
  - half: addr[1]?1100:0011
  - word: 1111
- Write data replication:
  - byte: {4{d[7:0]}}
  - half: {2{d[15:0]}}
  - word: d
- Load extraction: select the lane by addr[1:0] (half by addr[1]), then extend per sign_ext_in.
- dmem_ack outside IDLE-with-op or WAIT is ignored.
- Reset (async, any state):
  - FSM goes to IDLE; counter, load_q and bus_err_q clear to 0.
  - While rst=0: dmem_req=0, stall=0, RegWrite_out=0, MemToReg_out=0, misalign=0, bus_err=0.
  - An outstanding access is abandoned; no response is expected.
- Back-to-back memory ops: DONE -> IDLE; a new op issues a request in the next cycle (one bubble-free handoff).

Decomposition:
- Shared package core_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - FSM state encodings MA_IDLE, MA_WAIT, MA_DONE.
- One combinational sub-module, load_align (addr[1:0], size, sign_ext, rdata -> 32-bit result), reusable by a future cache.
- Store lane steering stays inline.

Test Plan:
- Non-memory op, RegWrite_in=1, alu_out_in=0x1234, rd=5 -> stall=0, no dmem_req; outputs pass through in the same cycle.
- LW at 0x100 with ack in the same cycle, rdata=0xDEADBEEF -> stall 1 cycle; DONE has mem_data_out=0xDEADBEEF, RegWrite_out=1.
- LB signed at 0x103, ack after 3 WAIT cycles, rdata=0x80FFFFFF -> mem_data_out=0xFFFFFF80; LBU gives 0x00000080; stall high 4 cycles.
- SH at 0x102, data 0x0000ABCD -> dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_we=1.
- LW at 0x101 -> misalign=1, no request, RegWrite_out=0, stall=0. Separately, no ack for 255 WAIT cycles -> bus_err=1 in DONE, RegWrite_out=0.
- Assert rst low in the 2nd WAIT cycle -> dmem_req and stall drop immediately. After release, FSM is IDLE and the next LW completes normally.
